dr32e_id_seq: RTL and testbench

DR32E_ID_SEQ -- requirements
Module: dr32e_id_seq

---
 rtl/dr32e_pkg.sv | 18 +
 rtl/dr32e_sat_counter.sv | 19 +
 rtl/dr32e_id_seq.sv | 133 +++++++++++++
 tb/tb_dr32e_id_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dr32e_pkg.sv
// Shared types for the dr32e decode-stage sequencer.
package dr32e_pkg;

  typedef enum logic [1:0] {RV32MNone, RV32MSlow, RV32MFast} rv32m_e;

  typedef enum logic [0:0] {ID_FIRST, ID_MULTI} id_state_e;

  typedef enum logic [2:0] {
    MC_NONE,
    MC_MULTDIV,
    MC_LSU,
    MC_JUMP,
    MC_BRANCH
  } mc_kind_e;

  localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/dr32e_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module dr32e_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      count_o <= '0;
    end else if (en_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dr32e_id_seq.sv
// Decode-stage instruction sequencer: single/multi-cycle issue and completion.
// Optional stall-cycle counter built when DR32E_ID_PERF_CNT_EN is defined.
module dr32e_id_seq
  import dr32e_pkg::*;
#(
  parameter rv32m_e RV32M = RV32MFast
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic        flush_i,
  input  logic        illegal_insn_i,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic        data_req_i,
  input  logic        jump_in_dec_i,
  input  logic        branch_in_dec_i,
  input  logic        branch_taken_i,
  input  logic        multdiv_done_i,
  input  logic        lsu_resp_valid_i,
  output logic        instr_first_cycle_o,
  output logic        id_in_ready_o,
  output logic        instr_done_o,
  output logic        exc_req_o,
  output logic        multdiv_start_o,
  output logic        lsu_req_o,
  output logic        jump_set_o,
  output logic        branch_set_o,
  output logic        stall_o,
  output logic [31:0] stall_cycles_o
);

  localparam logic MULTDIV_LEGAL = (RV32M != RV32MNone);

  id_state_e state_q, state_d;
  mc_kind_e  kind_q, kind_d;

  logic multdiv_insn;
  logic illegal_eff;
  logic mc_complete;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ID_FIRST;
      kind_q  <= MC_NONE;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    kind_d              = kind_q;
    instr_first_cycle_o = 1'b0;
    id_in_ready_o       = 1'b0;
    instr_done_o        = 1'b0;
    exc_req_o           = 1'b0;
    multdiv_start_o     = 1'b0;
    lsu_req_o           = 1'b0;
    jump_set_o          = 1'b0;
    branch_set_o        = 1'b0;
    stall_o             = 1'b0;

    multdiv_insn = mult_en_i | div_en_i;
    illegal_eff  = illegal_insn_i | (multdiv_insn & ~MULTDIV_LEGAL);

    // Jump/branch tails (and a stray MC_NONE) finish after one cycle.
    unique case (kind_q)
      MC_MULTDIV: mc_complete = multdiv_done_i;
      MC_LSU:     mc_complete = lsu_resp_valid_i;
      default:    mc_complete = 1'b1;
    endcase

    if (!rst_ni) begin
      state_d = ID_FIRST;
      kind_d  = MC_NONE;
    end else begin
      instr_first_cycle_o = (state_q == ID_FIRST) & instr_valid_i;
      stall_o             = (state_q == ID_MULTI) & ~mc_complete;

      if (flush_i) begin
        state_d       = ID_FIRST;
        kind_d        = MC_NONE;
        id_in_ready_o = 1'b1;
      end else if (state_q == ID_FIRST) begin
        if (!instr_valid_i) begin
          id_in_ready_o = 1'b1;
        end else if (illegal_eff) begin
          exc_req_o = 1'b1;
        end else if (multdiv_insn) begin
          multdiv_start_o = 1'b1;
          state_d         = ID_MULTI;
          kind_d          = MC_MULTDIV;
        end else if (data_req_i) begin
          lsu_req_o = 1'b1;
          state_d   = ID_MULTI;
          kind_d    = MC_LSU;
        end else if (jump_in_dec_i) begin
          jump_set_o = 1'b1;
          state_d    = ID_MULTI;
          kind_d     = MC_JUMP;
        end else if (branch_in_dec_i && branch_taken_i) begin
          branch_set_o = 1'b1;
          state_d      = ID_MULTI;
          kind_d       = MC_BRANCH;
        end else begin
          instr_done_o  = 1'b1;
          id_in_ready_o = 1'b1;
        end
      end else if (mc_complete) begin
        instr_done_o  = 1'b1;
        id_in_ready_o = 1'b1;
        state_d       = ID_FIRST;
        kind_d        = MC_NONE;
      end
    end
  end

`ifdef DR32E_ID_PERF_CNT_EN
  dr32e_sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_ni),
    .en_i   (stall_o),
    .count_o(stall_cycles_o)
  );
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_dr32e_id_seq.sv
// Bench for dr32e_id_seq: directed vector table plus randomized run against a reference model.
module tb_dr32e_id_seq;

  logic        clk;
  logic        rst_ni;
  logic        instr_valid_i, flush_i, illegal_insn_i, mult_en_i, div_en_i;
  logic        data_req_i, jump_in_dec_i, branch_in_dec_i, branch_taken_i;
  logic        multdiv_done_i, lsu_resp_valid_i;
  logic        instr_first_cycle_o, id_in_ready_o, instr_done_o, exc_req_o;
  logic        multdiv_start_o, lsu_req_o, jump_set_o, branch_set_o, stall_o;
  logic [31:0] stall_cycles_o;

  dr32e_id_seq dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .instr_valid_i      (instr_valid_i),
    .flush_i            (flush_i),
    .illegal_insn_i     (illegal_insn_i),
    .mult_en_i          (mult_en_i),
    .div_en_i           (div_en_i),
    .data_req_i         (data_req_i),
    .jump_in_dec_i      (jump_in_dec_i),
    .branch_in_dec_i    (branch_in_dec_i),
    .branch_taken_i     (branch_taken_i),
    .multdiv_done_i     (multdiv_done_i),
    .lsu_resp_valid_i   (lsu_resp_valid_i),
    .instr_first_cycle_o(instr_first_cycle_o),
    .id_in_ready_o      (id_in_ready_o),
    .instr_done_o       (instr_done_o),
    .exc_req_o          (exc_req_o),
    .multdiv_start_o    (multdiv_start_o),
    .lsu_req_o          (lsu_req_o),
    .jump_set_o         (jump_set_o),
    .branch_set_o       (branch_set_o),
    .stall_o            (stall_o),
    .stall_cycles_o     (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DR32E_ID_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
  localparam int MUL_STALLS = 3;
`else
  localparam bit CNT_EN = 1'b0;
  localparam int MUL_STALLS = 0;
`endif

  // Stimulus bit masks (S_RST means reset asserted)
  localparam logic [11:0] S_RST = 12'h800, S_V  = 12'h400, S_F  = 12'h200, S_IL = 12'h100;
  localparam logic [11:0] S_MU  = 12'h080, S_DV = 12'h040, S_DR = 12'h020, S_JP = 12'h010;
  localparam logic [11:0] S_BR  = 12'h008, S_TK = 12'h004, S_MD = 12'h002, S_LR = 12'h001;
  localparam logic [11:0] S_0   = 12'h000;
  // Output bit masks
  localparam logic [8:0] O_FIRST = 9'h100, O_RDY = 9'h080, O_DONE = 9'h040, O_EXC = 9'h020;
  localparam logic [8:0] O_MST   = 9'h010, O_LRQ = 9'h008, O_JS   = 9'h004, O_BS  = 9'h002;
  localparam logic [8:0] O_STL   = 9'h001, O_0   = 9'h000;

  typedef struct {
    string       name;
    logic [11:0] s;
    logic [8:0]  e;
    int          cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: what the stage is waiting on ("none", multdiv result, lsu response, one-cycle tail)
  typedef enum int {W_NONE, W_MULTDIV, W_LSU, W_TAIL} wait_e;
  wait_e       m_wait = W_NONE;
  longint      m_cnt = 0;
  bit          m_cnt_known = 1'b0;

  function automatic logic [8:0] model(input logic [11:0] s, output wait_e nxt);
    logic [8:0] o;
    bit         finished;
    o   = O_0;
    nxt = m_wait;
    if ((s & S_RST) != 0) begin
      nxt = W_NONE;
      return O_0;
    end
    if (m_wait == W_NONE && (s & S_V) != 0) o |= O_FIRST;
    finished = (m_wait == W_MULTDIV) ? ((s & S_MD) != 0) :
               (m_wait == W_LSU)     ? ((s & S_LR) != 0) : 1'b1;
    if (m_wait != W_NONE && !finished) o |= O_STL;
    if ((s & S_F) != 0) begin
      nxt = W_NONE;
      return o | O_RDY;
    end
    if (m_wait == W_NONE) begin
      if ((s & S_V) == 0)                  o |= O_RDY;
      else if ((s & S_IL) != 0)            o |= O_EXC;
      else if ((s & (S_MU | S_DV)) != 0) begin o |= O_MST; nxt = W_MULTDIV; end
      else if ((s & S_DR) != 0)          begin o |= O_LRQ; nxt = W_LSU;     end
      else if ((s & S_JP) != 0)          begin o |= O_JS;  nxt = W_TAIL;    end
      else if ((s & (S_BR | S_TK)) == (S_BR | S_TK)) begin o |= O_BS; nxt = W_TAIL; end
      else                                 o |= O_DONE | O_RDY;
    end else if (finished) begin
      o  |= O_DONE | O_RDY;
      nxt = W_NONE;
    end
    return o;
  endfunction

  function automatic void check_vec(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs {first,rdy,done,exc,mst,lrq,js,bs,stall} got %b expected %b",
               name, act, exp);
    end
  endfunction

  function automatic void check_cnt(input string name, input logic [31:0] act, input longint exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: stall_cycles_o got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic step(input string name, input logic [11:0] s, input bit use_tbl,
                      input logic [8:0] tbl_e, input int tbl_cnt);
    logic [8:0] mexp, act;
    wait_e      nxt;
    @(negedge clk);
    rst_ni           = ~s[11];
    instr_valid_i    = s[10];
    flush_i          = s[9];
    illegal_insn_i   = s[8];
    mult_en_i        = s[7];
    div_en_i         = s[6];
    data_req_i       = s[5];
    jump_in_dec_i    = s[4];
    branch_in_dec_i  = s[3];
    branch_taken_i   = s[2];
    multdiv_done_i   = s[1];
    lsu_resp_valid_i = s[0];
    #1;
    act  = {instr_first_cycle_o, id_in_ready_o, instr_done_o, exc_req_o, multdiv_start_o,
            lsu_req_o, jump_set_o, branch_set_o, stall_o};
    mexp = model(s, nxt);
    check_vec(name, act, use_tbl ? tbl_e : mexp);
    if (m_cnt_known) check_cnt(name, stall_cycles_o, CNT_EN ? m_cnt : 0);
    if (tbl_cnt >= 0) check_cnt({name, "_cnt"}, stall_cycles_o, tbl_cnt);
    // Counter update at the coming edge
    if (s[11]) begin
      m_cnt       = 0;
      m_cnt_known = 1'b1;
    end else if ((mexp & O_STL) != 0 && m_cnt < 64'hFFFF_FFFF) begin
      m_cnt++;
    end
    m_wait = nxt;
  endtask

  function automatic void add(input string n, input logic [11:0] s, input logic [8:0] e,
                              input int c = -1);
    tbl.push_back('{n, s, e, c});
  endfunction

  initial begin
    rst_ni = 1'b0; instr_valid_i = 1'b0; flush_i = 1'b0; illegal_insn_i = 1'b0;
    mult_en_i = 1'b0; div_en_i = 1'b0; data_req_i = 1'b0; jump_in_dec_i = 1'b0;
    branch_in_dec_i = 1'b0; branch_taken_i = 1'b0; multdiv_done_i = 1'b0;
    lsu_resp_valid_i = 1'b0;

    add("reset",          S_RST,                 O_0);
    add("reset_busy_in",  S_RST | S_V | S_MU,    O_0);
    add("idle",           S_0,                   O_RDY, 0);
    add("add",            S_V,                   O_FIRST | O_RDY | O_DONE);
    add("mul_start",      S_V | S_MU,            O_FIRST | O_MST);
    add("mul_wait1",      S_V,                   O_STL);
    add("mul_wait2",      S_V,                   O_STL);
    add("mul_wait3",      S_V,                   O_STL);
    add("mul_done",       S_V | S_MD,            O_RDY | O_DONE, MUL_STALLS);
    add("div_start",      S_V | S_DV | S_DR,     O_FIRST | O_MST);
    add("div_wrong_done", S_V | S_LR,            O_STL);
    add("div_done",       S_V | S_MD,            O_RDY | O_DONE);
    add("beq_taken",      S_V | S_BR | S_TK,     O_FIRST | O_BS);
    add("beq_tail",       S_V,                   O_RDY | O_DONE);
    add("beq_not_taken",  S_V | S_BR,            O_FIRST | O_RDY | O_DONE);
    add("jal",            S_V | S_JP | S_BR | S_TK, O_FIRST | O_JS);
    add("jal_tail",       S_V | S_MD,            O_RDY | O_DONE);
    add("lw_req",         S_V | S_DR | S_JP,     O_FIRST | O_LRQ);
    add("lw_wait",        S_V | S_MD,            O_STL);
    add("lw_flush_resp",  S_V | S_F | S_LR,      O_RDY);
    add("after_flush",    S_0,                   O_RDY);
    add("illegal_mul",    S_V | S_IL | S_MU,     O_FIRST | O_EXC);
    add("after_illegal",  S_0,                   O_RDY);
    add("flush_first",    S_V | S_MU | S_F,      O_FIRST | O_RDY);
    add("no_valid_mul",   S_MU | S_DR,           O_RDY);
    add("sw_req",         S_V | S_DR,            O_FIRST | O_LRQ);
    add("sw_wait",        S_V,                   O_STL);
    add("rst_mid_lsu",    S_RST | S_V | S_LR,    O_0);
    add("after_rst",      S_0,                   O_RDY, 0);
    add("add_after_rst",  S_V,                   O_FIRST | O_RDY | O_DONE);

    foreach (tbl[i]) step(tbl[i].name, tbl[i].s, 1'b1, tbl[i].e, tbl[i].cnt);

    for (int i = 0; i < 3000; i++) begin
      logic [11:0] s;
      s = 12'($urandom) & 12'h7FF;
      if ($urandom_range(0, 7) != 0)  s &= ~S_F;
      if ($urandom_range(0, 3) != 0)  s &= ~S_IL;
      if ($urandom_range(0, 2) != 0)  s &= ~(S_MU | S_DV);
      if ($urandom_range(0, 2) != 0)  s &= ~(S_MD | S_LR);
      if ($urandom_range(0, 63) == 0) s |= S_RST;
      step("random", s, 1'b0, O_0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
